// File: rtl/ram_dma_engine.sv
`default_nettype none
// ============================================================================
// Module   : ram_dma_engine
// Purpose  : Block copy / fill / additive checksum engine driving RAM16K.
// Revision : 1.0 - initial release
// ============================================================================
module ram_dma_engine #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_load,
    output logic [DATA_WIDTH-1:0] ram_in,
    input  logic [DATA_WIDTH-1:0] ram_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WR    = 3'd2,
        S_SUM   = 3'd3,
        S_DRAIN = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [1:0]            c_mode_copy = 2'd0;
    localparam logic [1:0]            c_mode_fill = 2'd1;
    localparam logic [1:0]            c_mode_sum  = 2'd2;
    localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   c_len_one   = (ADDR_WIDTH+1)'(1);

    state_t                r_state;
    logic [1:0]            r_mode;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_copy_wr;

    logic [ADDR_WIDTH-1:0] w_idx_lo;
    logic [ADDR_WIDTH-1:0] w_src_next;
    logic [ADDR_WIDTH-1:0] w_dst_next;
    logic [ADDR_WIDTH-1:0] w_dst_cur;
    logic                  w_last;
    logic                  w_sum_valid;
    logic                  w_count_inc;
    logic                  w_idle;

    assign w_idx_lo    = r_idx[ADDR_WIDTH-1:0];
    assign w_src_next  = r_src + w_idx_lo + c_addr_one;
    assign w_dst_next  = r_dst + w_idx_lo + c_addr_one;
    assign w_dst_cur   = r_dst + w_idx_lo;
    assign w_last      = (r_idx == (r_len - c_len_one));
    // Read data lags its address by one cycle, so the first SUM cycle has nothing to add.
    assign w_sum_valid = ((r_state == S_SUM) && (r_idx != '0)) || (r_state == S_DRAIN);
    assign w_count_inc = (r_state == S_WR) || w_sum_valid;
    assign w_idle      = (r_state == S_IDLE) || (r_state == S_FIN);

    // Copy writes forward the RAM read data of the preceding RD cycle directly.
    assign ram_in = r_copy_wr ? ram_out : r_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_copy_wr   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            result      <= '0;
            count       <= '0;
            ram_address <= '0;
            ram_load    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            // The access presented this cycle always completes, even under abort.
            if (w_count_inc) begin
                count <= count + c_len_one;
            end
            if (w_sum_valid) begin
                result <= result + ram_out;
            end

            if (w_idle) begin
                r_state <= S_IDLE;
                if (start) begin
                    r_mode  <= mode;
                    r_src   <= src;
                    r_dst   <= dst;
                    r_len   <= len;
                    r_wdata <= fill_value;
                    r_idx   <= '0;
                    count   <= '0;
                    if (mode == c_mode_sum) begin
                        result <= '0;
                    end
                    if ((len == '0) || (mode == 2'd3)) begin
                        r_state <= S_FIN;
                        done    <= 1'b1;
                    end else begin
                        busy <= 1'b1;
                        case (mode)
                            c_mode_copy: begin
                                r_state     <= S_RD;
                                ram_address <= src;
                                ram_load    <= 1'b0;
                                r_copy_wr   <= 1'b0;
                            end
                            c_mode_fill: begin
                                r_state     <= S_WR;
                                ram_address <= dst;
                                ram_load    <= 1'b1;
                                r_copy_wr   <= 1'b0;
                            end
                            default: begin
                                r_state     <= S_SUM;
                                ram_address <= src;
                                ram_load    <= 1'b0;
                                r_copy_wr   <= 1'b0;
                            end
                        endcase
                    end
                end
            end else if (abort) begin
                r_state   <= S_IDLE;
                busy      <= 1'b0;
                aborted   <= 1'b1;
                ram_load  <= 1'b0;
                r_copy_wr <= 1'b0;
            end else begin
                case (r_state)
                    S_RD: begin
                        r_state     <= S_WR;
                        ram_address <= w_dst_cur;
                        ram_load    <= 1'b1;
                        r_copy_wr   <= 1'b1;
                    end
                    S_WR: begin
                        if (w_last) begin
                            r_state   <= S_FIN;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            ram_load  <= 1'b0;
                            r_copy_wr <= 1'b0;
                        end else begin
                            r_idx <= r_idx + c_len_one;
                            if (r_mode == c_mode_copy) begin
                                r_state     <= S_RD;
                                ram_address <= w_src_next;
                                ram_load    <= 1'b0;
                                r_copy_wr   <= 1'b0;
                            end else begin
                                ram_address <= w_dst_next;
                            end
                        end
                    end
                    S_SUM: begin
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_idx       <= r_idx + c_len_one;
                            ram_address <= w_src_next;
                        end
                    end
                    S_DRAIN: begin
                        r_state <= S_FIN;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_dma_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_dma_engine
// Purpose  : Scoreboard bench for ram_dma_engine with a behavioural RAM16K.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_dma_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [13:0] src;
    logic [13:0] dst;
    logic [14:0] len;
    logic [15:0] fill_value;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] result;
    logic [14:0] count;
    logic [13:0] ram_address;
    logic        ram_load;
    logic [15:0] ram_in;
    logic [15:0] ram_out;

    logic        pre_we;
    logic [13:0] pre_addr;
    logic [15:0] pre_data;
    logic [15:0] mem [0:16383];

    typedef struct packed {
        logic        is_abort;
        logic [14:0] cnt;
        logic [15:0] res;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks;
    int   errors;
    int   mon_busy;
    int   mon_writes;
    int   mon_done;
    int   mon_abort;

    ram_dma_engine #(.ADDR_WIDTH(14), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill_value(fill_value), .abort(abort), .busy(busy), .done(done),
        .aborted(aborted), .result(result), .count(count), .ram_address(ram_address),
        .ram_load(ram_load), .ram_in(ram_in), .ram_out(ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM16K model: write on load, registered read of the presented address.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_load) begin
            mem[ram_address] <= ram_in;
        end
        ram_out <= mem[ram_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: counts activity and scores every completion pulse against the queue.
    always @(negedge clk) begin
        if (busy === 1'b1) mon_busy++;
        if (ram_load === 1'b1) mon_writes++;
        if (done === 1'b1) mon_done++;
        if (aborted === 1'b1) mon_abort++;
        if ((done === 1'b1) || (aborted === 1'b1)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("completion_kind_aborted", 32'(aborted), 32'(e.is_abort));
                check("count", 32'(count), 32'(e.cnt));
                check("result", 32'(result), 32'(e.res));
            end
        end
    end

    task automatic do_start(input logic [1:0] m, input logic [13:0] s, input logic [13:0] d,
                            input logic [14:0] l, input logic [15:0] f);
        start = 1'b1; mode = m; src = s; dst = d; len = l; fill_value = f;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic preload(input logic [13:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!((done === 1'b1) || (aborted === 1'b1)) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check("completion_seen", 32'(done | aborted), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0, w0, d0, a0, n;
        checks = 0; errors = 0;
        mon_busy = 0; mon_writes = 0; mon_done = 0; mon_abort = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; src = '0; dst = '0;
        len = '0; fill_value = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done_aborted", 32'({done, aborted}), 32'd0);
        check("reset_result_count", 32'({result, count}), 32'd0);
        check("reset_ram_if", 32'({ram_address, ram_load, ram_in}), 32'd0);
        @(posedge clk); #1;

        // Fill across the top of memory.
        b0 = mon_busy; w0 = mon_writes;
        exp_q.push_back('{1'b0, 15'd4, 16'h0000});
        do_start(2'd1, 14'd0, 14'h3FFE, 15'd4, 16'hA5A5);
        wait_done(20);
        @(posedge clk); #1;
        check("fill_3ffe", 32'(mem[14'h3FFE]), 32'hA5A5);
        check("fill_3fff", 32'(mem[14'h3FFF]), 32'hA5A5);
        check("fill_0000", 32'(mem[14'h0000]), 32'hA5A5);
        check("fill_0001", 32'(mem[14'h0001]), 32'hA5A5);
        check("fill_busy_cycles", 32'(mon_busy - b0), 32'd4);
        check("fill_writes", 32'(mon_writes - w0), 32'd4);

        // Copy 100..103 -> 200..203.
        for (int i = 0; i < 4; i++) preload(14'(100 + i), 16'(i + 1));
        b0 = mon_busy; d0 = mon_done;
        exp_q.push_back('{1'b0, 15'd4, 16'h0000});
        do_start(2'd0, 14'd100, 14'd200, 15'd4, 16'h0000);
        wait_done(40);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check("copy_dst_word", 32'(mem[14'(200 + i)]), 32'(i + 1));
            check("copy_src_word", 32'(mem[14'(100 + i)]), 32'(i + 1));
        end
        check("copy_busy_cycles", 32'(mon_busy - b0), 32'd8);
        check("copy_done_pulses", 32'(mon_done - d0), 32'd1);

        // Checksum with 16-bit wrap: 0xFFFF + 2 + 0x10 = 0x0011.
        preload(14'd0, 16'hFFFF);
        preload(14'd1, 16'h0002);
        preload(14'd2, 16'h0010);
        b0 = mon_busy;
        exp_q.push_back('{1'b0, 15'd3, 16'h0011});
        do_start(2'd2, 14'd0, 14'd0, 15'd3, 16'h0000);
        wait_done(20);
        @(posedge clk); #1;
        check("sum_busy_cycles", 32'(mon_busy - b0), 32'd4);

        // Zero-length copy completes in the cycle after start.
        b0 = mon_busy; w0 = mon_writes; d0 = mon_done;
        exp_q.push_back('{1'b0, 15'd0, 16'h0011});
        do_start(2'd0, 14'd5, 14'd6, 15'd0, 16'h0000);
        @(negedge clk);
        check("len0_done_next_cycle", 32'(done), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("len0_busy_cycles", 32'(mon_busy - b0), 32'd0);
        check("len0_writes", 32'(mon_writes - w0), 32'd0);
        check("len0_done_pulses", 32'(mon_done - d0), 32'd1);

        // Abort a long fill on its 10th busy cycle.
        w0 = mon_writes; d0 = mon_done; a0 = mon_abort;
        exp_q.push_back('{1'b1, 15'd10, 16'h0011});
        do_start(2'd1, 14'd0, 14'd1000, 15'd100, 16'h1234);
        n = 0;
        for (int g = 0; (g < 50) && (n < 10); g++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_pulse_next_cycle", 32'({aborted, busy}), 32'b10);
        repeat (4) @(posedge clk);
        #1;
        check("abort_writes", 32'(mon_writes - w0), 32'd10);
        check("abort_last_word", 32'(mem[14'd1009]), 32'h1234);
        check("abort_no_extra_word", 32'(mem[14'd1010] === 16'h1234), 32'd0);
        check("abort_done_pulses", 32'(mon_done - d0), 32'd0);
        check("abort_pulses", 32'(mon_abort - a0), 32'd1);
        check("abort_idle_load", 32'({busy, ram_load}), 32'd0);

        // Reset in the 3rd busy cycle of a copy, then a checksum right after.
        d0 = mon_done; a0 = mon_abort;
        do_start(2'd0, 14'd100, 14'd300, 15'd8, 16'h0000);
        n = 0;
        for (int g = 0; (g < 50) && (n < 3); g++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.push_back('{1'b0, 15'd4, 16'd10});
        start = 1'b1; mode = 2'd2; src = 14'd100; dst = 14'd0; len = 15'd4; fill_value = 16'h0;
        @(negedge clk);
        check("rst_busy_flags", 32'({busy, done, aborted}), 32'd0);
        check("rst_result_count", 32'({result, count}), 32'd0);
        check("rst_ram_if", 32'({ram_address, ram_load, ram_in}), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(30);
        @(posedge clk); #1;
        check("rst_done_pulses", 32'(mon_done - d0), 32'd1);
        check("rst_abort_pulses", 32'(mon_abort - a0), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
